fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Hardware instruction-fetch sequencer. Replaces the bench-driven byte-by-byte fetch: reads INSTR_BYTES consecutive bytes from the byte-wide flash, assembles a little-endian instruction word, and hands it to decode over a valid/ready handshake.
- Owns the fetch PC. Supports sequential advance, redirect (branch/jump) and run/halt control.
- Sits between the flash block and the control unit.

Parameters:
- ADDR_WIDTH, 24, flash byte-address width
- INSTR_BYTES, 4, bytes per instruction (1..8)
- READ_LATENCY, 3, cycles from address presentation to valid flash_out (1..7)
- RESET_PC, 0, fetch PC after reset

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- run  in  1  level; 1 = fetch continuously, 0 = halt at next instruction boundary
- redirect  in  1  one-cycle pulse; load PC from redirect_addr
- redirect_addr  in  ADDR_WIDTH  new fetch address
- flash_re  out  1  flash read enable
- flash_addr  out  ADDR_WIDTH  flash byte address
- flash_out  in  8  flash read data
- instr_valid  out  1  instr/instr_pc hold a complete instruction
- instr_ready  in  1  decode accepts the instruction
- instr  out  8*INSTR_BYTES  assembled instruction; byte k in bits [8k+7:8k]
- instr_pc  out  ADDR_WIDTH  address of byte 0 of instr
- busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, reset=0): state IDLE; pc=RESET_PC; flash_re=0; flash_addr=0; instr_valid=0; instr=0; instr_pc=0; busy=0; byte and latency counters cleared. Reset mid-fetch discards all partial bytes.
- All outputs are registered.
- FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if run=1, go to ISSUE with byte_idx=0.
- ISSUE (1 cycle): flash_re=1; flash_addr = pc + byte_idx, taken modulo 2^ADDR_WIDTH; load lat_cnt; go to WAIT.
- WAIT: lat_cnt counts down. flash_out is sampled at the rising edge ending cycle c_k+READ_LATENCY, where c_k is byte k's ISSUE cycle. The sample is stored in lane byte_idx.
  - If byte_idx < INSTR_BYTES-1: increment byte_idx and go to ISSUE.
  - Otherwise: go to HOLD with instr_valid=1 and instr_pc=pc.
- Latency: instr_valid rises in cycle INSTR_BYTES*(READ_LATENCY+1) after the first ISSUE cycle (16 with defaults).
- flash_re stays 1 from the first ISSUE through the final sample, then drops to 0 in HOLD and IDLE.
- HOLD: instr, instr_pc and instr_valid stay stable until the handshake (instr_valid & instr_ready at a rising edge). On the handshake:
  - pc = pc + INSTR_BYTES (wraps);
  - instr_valid drops the next cycle;
  - go to ISSUE if run=1, else IDLE.
- HOLD has no back-to-back overlap: the next fetch starts only after acceptance.
- run=0 during ISSUE/WAIT: the current instruction completes and is delivered; the halt takes effect at the HOLD handshake.
- redirect=1 (any state, highest priority):
  - pc=redirect_addr; byte_idx=0; partial bytes discarded; instr_valid=0 the next cycle;
  - next state is ISSUE if run=1, else IDLE.
  - Simultaneous handshake and redirect: the instruction counts as accepted, and pc=redirect_addr (not pc+INSTR_BYTES).
  - Redirect in IDLE with run=0 only loads pc.
- No alignment check on redirect_addr: any byte address is fetched as given.
- Flash data arriving after a redirect for an aborted read is ignored, because the latency counter restarts.
- PC arithmetic is ADDR_WIDTH bits, unsigned, wrapping: 0xFFFFFC+4 = 0x000000.

Test Plan:
- Reset/idle: hold reset=0, then release with run=0 -> all outputs 0, busy=0, pc=0; no flash_re activity for 20 cycles.
- Sequential fetch: flash preloaded with 02000283 at 0x0 and 02100303 at 0x4, run=1, instr_ready=1 -> instr_valid in cycle 16 with instr=32'h02000283 and instr_pc=0; second instruction 32'h02100303 with instr_pc=4, valid 17 cycles after the first handshake.
- Backpressure: instr_ready=0 for 10 cycles -> instr and instr_pc stable, flash_re=0, no new addresses; assert ready -> one handshake, pc advances by 4.
- Redirect mid-fetch: redirect=1 with redirect_addr=0x0C after 2 bytes captured -> partial bytes dropped; next flash_addr sequence is 0x0C,0x0D,0x0E,0x0F; instr=32'h02700123 with instr_pc=0x0C. Repeat with redirect coincident with a handshake -> next instr_pc=redirect_addr.
- Wrap and parameters: READ_LATENCY=1, INSTR_BYTES=2, redirect to 0xFFFFFF -> addresses 0xFFFFFF then 0x000000; instr_valid 4 cycles after ISSUE; next pc=0x000001.
- Reset mid-operation: reset=0 asynchronously during WAIT of byte 2 -> outputs clear immediately without a clock edge; after release, fetch restarts at RESET_PC with byte 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: walks the fetch PC through byte-wide flash,
// assembles INSTR_BYTES bytes into a little-endian word and offers it to
// decode over a valid/ready handshake. Redirects reload the PC from any
// state and throw away a partially assembled word.
module fetch_sequencer #(
    parameter int                    ADDR_WIDTH   = 24,
    parameter int                    INSTR_BYTES  = 4,
    parameter int                    READ_LATENCY = 3,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC     = {ADDR_WIDTH{1'b0}}
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     run,
    input  logic                     redirect,
    input  logic [ADDR_WIDTH-1:0]    redirect_addr,
    output logic                     flash_re,
    output logic [ADDR_WIDTH-1:0]    flash_addr,
    input  logic [7:0]               flash_out,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic [ADDR_WIDTH-1:0]    instr_pc,
    output logic                     busy
);

    localparam int                    IW       = 8 * INSTR_BYTES;
    localparam int                    IDX_W    = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [IDX_W-1:0]      LAST_IDX = IDX_W'(INSTR_BYTES - 1);
    localparam logic [2:0]            LAT_LOAD = 3'(READ_LATENCY - 1);
    localparam logic [ADDR_WIDTH-1:0] PC_STEP  = ADDR_WIDTH'(INSTR_BYTES);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_pc;
    logic [IDX_W-1:0]        r_byte_idx;
    logic [2:0]              r_lat_cnt;
    logic [IW-1:0]           r_asm;
    logic [IW-1:0]           r_instr;
    logic [ADDR_WIDTH-1:0]   r_instr_pc;
    logic                    r_instr_valid;
    logic                    r_flash_re;
    logic [ADDR_WIDTH-1:0]   r_flash_addr;
    logic                    r_busy;

    state_t                  w_state_n;
    logic [ADDR_WIDTH-1:0]   w_pc_n;
    logic [IDX_W-1:0]        w_idx_n;
    logic [2:0]              w_lat_n;
    logic [IW-1:0]           w_asm_n;
    logic [IW-1:0]           w_instr_n;
    logic [ADDR_WIDTH-1:0]   w_instr_pc_n;
    logic                    w_valid_n;
    logic                    w_re_n;
    logic [ADDR_WIDTH-1:0]   w_addr_n;
    logic                    w_busy_n;
    logic [IW-1:0]           w_captured;

    // Merge the current flash byte into the lane selected by the byte index.
    always_comb begin
        w_captured = r_asm;
        for (int k = 0; k < INSTR_BYTES; k++) begin
            if (r_byte_idx == IDX_W'(k)) begin
                w_captured[8*k +: 8] = flash_out;
            end else begin
                w_captured[8*k +: 8] = r_asm[8*k +: 8];
            end
        end
    end

    // Next-state and datapath update; redirect overrides every state.
    always_comb begin
        w_state_n    = r_state;
        w_pc_n       = r_pc;
        w_idx_n      = r_byte_idx;
        w_lat_n      = r_lat_cnt;
        w_asm_n      = r_asm;
        w_instr_n    = r_instr;
        w_instr_pc_n = r_instr_pc;
        w_valid_n    = r_instr_valid;
        if (redirect) begin
            // A handshake in the same cycle still counts as accepted, but the
            // redirect target wins over the sequential PC advance.
            w_pc_n    = redirect_addr;
            w_idx_n   = {IDX_W{1'b0}};
            w_lat_n   = 3'd0;
            w_asm_n   = {IW{1'b0}};
            w_valid_n = 1'b0;
            w_state_n = run ? S_ISSUE : S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (run) begin
                        w_idx_n   = {IDX_W{1'b0}};
                        w_state_n = S_ISSUE;
                    end else begin
                        w_state_n = S_IDLE;
                    end
                end
                S_ISSUE: begin
                    w_lat_n   = LAT_LOAD;
                    w_state_n = S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat_cnt == 3'd0) begin
                        if (r_byte_idx != LAST_IDX) begin
                            w_asm_n   = w_captured;
                            w_idx_n   = r_byte_idx + IDX_W'(1'b1);
                            w_state_n = S_ISSUE;
                        end else begin
                            w_instr_n    = w_captured;
                            w_instr_pc_n = r_pc;
                            w_valid_n    = 1'b1;
                            w_asm_n      = {IW{1'b0}};
                            w_state_n    = S_HOLD;
                        end
                    end else begin
                        w_lat_n = r_lat_cnt - 3'd1;
                    end
                end
                S_HOLD: begin
                    // No overlap: the next fetch only starts after acceptance.
                    if (r_instr_valid && instr_ready) begin
                        w_pc_n    = r_pc + PC_STEP;
                        w_idx_n   = {IDX_W{1'b0}};
                        w_valid_n = 1'b0;
                        w_state_n = run ? S_ISSUE : S_IDLE;
                    end else begin
                        w_state_n = S_HOLD;
                    end
                end
                default: begin
                    w_state_n = S_IDLE;
                end
            endcase
        end
    end

    // Flash-side outputs derived from the state being entered, so they are registered.
    always_comb begin
        w_re_n   = (w_state_n == S_ISSUE) || (w_state_n == S_WAIT);
        w_busy_n = (w_state_n != S_IDLE);
        if (w_state_n == S_ISSUE) begin
            w_addr_n = w_pc_n + ADDR_WIDTH'(w_idx_n);
        end else begin
            w_addr_n = r_flash_addr;
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_pc          <= RESET_PC;
            r_byte_idx    <= {IDX_W{1'b0}};
            r_lat_cnt     <= 3'd0;
            r_asm         <= {IW{1'b0}};
            r_instr       <= {IW{1'b0}};
            r_instr_pc    <= {ADDR_WIDTH{1'b0}};
            r_instr_valid <= 1'b0;
            r_flash_re    <= 1'b0;
            r_flash_addr  <= {ADDR_WIDTH{1'b0}};
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_n;
            r_pc          <= w_pc_n;
            r_byte_idx    <= w_idx_n;
            r_lat_cnt     <= w_lat_n;
            r_asm         <= w_asm_n;
            r_instr       <= w_instr_n;
            r_instr_pc    <= w_instr_pc_n;
            r_instr_valid <= w_valid_n;
            r_flash_re    <= w_re_n;
            r_flash_addr  <= w_addr_n;
            r_busy        <= w_busy_n;
        end
    end

    assign flash_re    = r_flash_re;
    assign flash_addr  = r_flash_addr;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign busy        = r_busy;

endmodule
